// File: rtl/atpg_pkg.sv
// Shared definitions for the ATPG pattern player: FSM states, default
// vector widths and the packed pattern record layout.
package atpg_pkg;

  localparam int NINPUTS  = 5;
  localparam int NOUTPUTS = 2;
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // One pattern record as written by the ATPG flow, at the default widths.
  typedef struct packed {
    logic [NINPUTS-1:0]  pi;
    logic [NOUTPUTS-1:0] xpct;
    logic [NOUTPUTS-1:0] mask;
    logic                last;
  } pat_rec_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; stops at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, hold at the maximum value, clear has priority.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/atpg_pattern_player.sv
// Applies one ATPG pattern record at a time to the alu block: drive PI,
// wait SETTLE cycles, strobe PO, masked compare, keep pass/fail statistics.
module atpg_pattern_player #(
  parameter int NINPUTS  = atpg_pkg::NINPUTS,
  parameter int NOUTPUTS = atpg_pkg::NOUTPUTS,
  parameter int SETTLE   = 4,
  parameter int CNT_W    = atpg_pkg::CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pat_valid,
  output logic                pat_ready,
  input  logic [NINPUTS-1:0]  pat_pi,
  input  logic [NOUTPUTS-1:0] pat_xpct,
  input  logic [NOUTPUTS-1:0] pat_mask,
  input  logic                pat_last,
  output logic [NINPUTS-1:0]  dut_pi,
  input  logic [NOUTPUTS-1:0] dut_po,
  output logic                fail_pulse,
  output logic [NOUTPUTS-1:0] fail_bits,
  output logic [CNT_W-1:0]    pat_count,
  output logic [CNT_W-1:0]    fail_count,
  output logic [CNT_W-1:0]    first_fail_idx,
  output logic                first_fail_vld,
  output logic                done
);

  import atpg_pkg::*;

  // Settle counter width; at least one bit so SETTLE=1 still elaborates.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t              state, state_nxt;
  logic [CW-1:0]       settle_cnt;
  logic                accept, strobe;
  logic [NOUTPUTS-1:0] xpct_q, mask_q, miss;
  logic                last_q;

  // Masked miscompare of the live PO against the registered expectation.
  assign miss = (dut_po ^ xpct_q) & mask_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a variable unassigned and infers a latch.
    state_nxt = state;
    pat_ready = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    strobe    = 1'b0;
    unique case (state)
      IDLE: begin
        // Hold ready low while reset is asserted.
        pat_ready = rst_n;
        if (pat_valid) begin
          accept    = 1'b1;
          state_nxt = APPLY;
        end
      end
      APPLY: begin
        if (settle_cnt == '0) state_nxt = STROBE;
      end
      STROBE: begin
        strobe    = 1'b1;
        state_nxt = last_q ? DONE : IDLE;
      end
      DONE: begin
        done = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Captured record fields; only read after an accept has loaded them.
  always_ff @(posedge clk) begin
    // NOTE: these data registers are deliberately not reset; nothing
    // observes them before the accept that writes them.
    if (accept) begin
      xpct_q <= pat_xpct;
      mask_q <= pat_mask;
      last_q <= pat_last;
    end
  end

  // PI drive, settle timing and strobe result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dut_pi         <= '0;
      settle_cnt     <= '0;
      fail_bits      <= '0;
      fail_pulse     <= 1'b0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      fail_pulse <= 1'b0;
      if (accept) begin
        dut_pi     <= pat_pi;
        settle_cnt <= CW'(SETTLE - 1);
      end else if ((state == APPLY) && (settle_cnt != '0)) begin
        settle_cnt <= settle_cnt - CW'(1);
      end
      if (strobe) begin
        fail_bits  <= miss;
        fail_pulse <= |miss;
        if ((|miss) && !first_fail_vld) begin
          first_fail_idx <= pat_count;
          first_fail_vld <= 1'b1;
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_pat_cnt (
    .clk   (clk),
    .clr   (~rst_n),
    .inc   (strobe),
    .count (pat_count)
  );

  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .clr   (~rst_n),
    .inc   (strobe & (|miss)),
    .count (fail_count)
  );

endmodule

// File: tb/tb_atpg_pattern_player.sv
// Directed bench for atpg_pattern_player: a default instance plus a
// CNT_W=3 instance sharing the same stimulus for the saturation scenario.
module tb_atpg_pattern_player;
  import atpg_pkg::*;

  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pat_valid;
  logic [4:0]  pat_pi;
  logic [1:0]  pat_xpct, pat_mask, dut_po;
  logic        pat_last;

  logic        pat_ready, fail_pulse, first_fail_vld, done;
  logic [4:0]  dut_pi;
  logic [1:0]  fail_bits;
  logic [15:0] pat_count, fail_count, first_fail_idx;

  logic        pat_ready_s, fail_pulse_s, first_fail_vld_s, done_s;
  logic [4:0]  dut_pi_s;
  logic [1:0]  fail_bits_s;
  logic [2:0]  pat_count_s, fail_count_s, first_fail_idx_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  atpg_pattern_player #(.NINPUTS(5), .NOUTPUTS(2), .SETTLE(SETTLE), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .pat_valid(pat_valid), .pat_ready(pat_ready),
    .pat_pi(pat_pi), .pat_xpct(pat_xpct), .pat_mask(pat_mask), .pat_last(pat_last),
    .dut_pi(dut_pi), .dut_po(dut_po), .fail_pulse(fail_pulse), .fail_bits(fail_bits),
    .pat_count(pat_count), .fail_count(fail_count), .first_fail_idx(first_fail_idx),
    .first_fail_vld(first_fail_vld), .done(done)
  );

  atpg_pattern_player #(.NINPUTS(5), .NOUTPUTS(2), .SETTLE(SETTLE), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .pat_valid(pat_valid), .pat_ready(pat_ready_s),
    .pat_pi(pat_pi), .pat_xpct(pat_xpct), .pat_mask(pat_mask), .pat_last(pat_last),
    .dut_pi(dut_pi_s), .dut_po(dut_po), .fail_pulse(fail_pulse_s), .fail_bits(fail_bits_s),
    .pat_count(pat_count_s), .fail_count(fail_count_s), .first_fail_idx(first_fail_idx_s),
    .first_fail_vld(first_fail_vld_s), .done(done_s)
  );

  function automatic pat_rec_t mk_rec(input logic [4:0] pi, input logic [1:0] xpct,
                                      input logic [1:0] mask, input logic last);
    pat_rec_t r;
    r.pi   = pi;
    r.xpct = xpct;
    r.mask = mask;
    r.last = last;
    return r;
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    pat_valid = 1'b0;
    pat_pi    = '0;
    pat_xpct  = '0;
    pat_mask  = '0;
    pat_last  = 1'b0;
    dut_po    = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offer one record, then return at the negedge right after its strobe edge.
  task automatic apply_pattern(input pat_rec_t r, input logic [1:0] po);
    int waited = 0;
    while (!pat_ready && waited < 32) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (pat_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_timeout: pat_ready=%b want 1 after %0d cycles", pat_ready, waited);
    end
    pat_pi    = r.pi;
    pat_xpct  = r.xpct;
    pat_mask  = r.mask;
    pat_last  = r.last;
    dut_po    = po;
    pat_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pat_valid = 1'b0;
    repeat (SETTLE + 1) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    pat_valid = 1'b1;
    pat_pi    = 5'b11111;
    pat_xpct  = '0;
    pat_mask  = '0;
    pat_last  = 1'b0;
    dut_po    = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    total++; if (pat_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_low: got %b want 0", pat_ready); end
    total++; if (dut_pi !== 5'b0) begin bad++; $display("FAIL reset_dut_pi: got %b want 00000", dut_pi); end
    total++; if (pat_count !== 16'd0 || fail_count !== 16'd0) begin bad++; $display("FAIL reset_counts: got %0d/%0d want 0/0", pat_count, fail_count); end
    total++; if ({fail_pulse, first_fail_vld, done} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {fail_pulse, first_fail_vld, done}); end
    total++; if (first_fail_idx !== 16'd0 || fail_bits !== 2'b00) begin bad++; $display("FAIL reset_idx_bits: got %0d/%b want 0/00", first_fail_idx, fail_bits); end
    pat_valid = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (pat_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_high: got %b want 1", pat_ready); end
  endtask

  task automatic test_pass();
    do_reset();
    pat_pi    = 5'b11101;
    pat_xpct  = 2'b10;
    pat_mask  = 2'b11;
    pat_last  = 1'b0;
    dut_po    = 2'b10;
    pat_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pat_valid = 1'b0;
    total++; if (dut_pi !== 5'b11101) begin bad++; $display("FAIL pass_dut_pi: got %b want 11101", dut_pi); end
    for (int k = 1; k <= SETTLE; k++) begin
      @(posedge clk);
      @(negedge clk);
      total++; if (pat_count !== 16'd0 || pat_ready !== 1'b0) begin bad++; $display("FAIL pass_early_strobe: edge %0d count=%0d ready=%b want 0/0", k, pat_count, pat_ready); end
    end
    @(posedge clk);
    @(negedge clk);
    total++; if (pat_count !== 16'd1) begin bad++; $display("FAIL pass_pat_count: got %0d want 1", pat_count); end
    total++; if (fail_count !== 16'd0 || fail_pulse !== 1'b0) begin bad++; $display("FAIL pass_no_fail: got count=%0d pulse=%b want 0/0", fail_count, fail_pulse); end
    total++; if (pat_ready !== 1'b1) begin bad++; $display("FAIL pass_ready_back: got %b want 1", pat_ready); end
    total++; if (dut_pi !== 5'b11101) begin bad++; $display("FAIL pass_pi_hold: got %b want 11101", dut_pi); end
  endtask

  task automatic test_fail();
    do_reset();
    apply_pattern(mk_rec(5'b01101, 2'b00, 2'b11, 1'b0), 2'b01);
    total++; if (fail_pulse !== 1'b1) begin bad++; $display("FAIL fail_pulse_hi: got %b want 1", fail_pulse); end
    total++; if (fail_bits !== 2'b01) begin bad++; $display("FAIL fail_bits: got %b want 01", fail_bits); end
    total++; if (fail_count !== 16'd1 || pat_count !== 16'd1) begin bad++; $display("FAIL fail_counts: got %0d/%0d want 1/1", fail_count, pat_count); end
    total++; if (first_fail_idx !== 16'd0 || first_fail_vld !== 1'b1) begin bad++; $display("FAIL fail_first: got idx=%0d vld=%b want 0/1", first_fail_idx, first_fail_vld); end
    @(posedge clk);
    @(negedge clk);
    total++; if (fail_pulse !== 1'b0) begin bad++; $display("FAIL fail_pulse_width: got %b want 0", fail_pulse); end
    total++; if (fail_bits !== 2'b01) begin bad++; $display("FAIL fail_bits_hold: got %b want 01", fail_bits); end
  endtask

  task automatic test_dont_care();
    do_reset();
    apply_pattern(mk_rec(5'b00011, 2'b00, 2'b10, 1'b0), 2'b01);
    total++; if (fail_pulse !== 1'b0 || fail_bits !== 2'b00) begin bad++; $display("FAIL dc_bit0: got pulse=%b bits=%b want 0/00", fail_pulse, fail_bits); end
    apply_pattern(mk_rec(5'b00110, 2'b00, 2'b00, 1'b0), 2'b11);
    total++; if (fail_pulse !== 1'b0 || fail_bits !== 2'b00) begin bad++; $display("FAIL dc_all_masked: got pulse=%b bits=%b want 0/00", fail_pulse, fail_bits); end
    total++; if (pat_count !== 16'd2 || fail_count !== 16'd0) begin bad++; $display("FAIL dc_counts: got %0d/%0d want 2/0", pat_count, fail_count); end
  endtask

  task automatic test_full_set();
    pat_rec_t  recs [5];
    logic [1:0] pos [5];
    recs[0] = mk_rec(5'b00001, 2'b01, 2'b11, 1'b0); pos[0] = 2'b01;
    recs[1] = mk_rec(5'b00010, 2'b10, 2'b01, 1'b0); pos[1] = 2'b00;
    recs[2] = mk_rec(5'b00100, 2'b11, 2'b11, 1'b0); pos[2] = 2'b10;
    recs[3] = mk_rec(5'b01000, 2'b00, 2'b00, 1'b0); pos[3] = 2'b11;
    recs[4] = mk_rec(5'b10000, 2'b11, 2'b11, 1'b1); pos[4] = 2'b11;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply_pattern(recs[i], pos[i]);
      if (i == 2) begin
        total++; if (fail_pulse !== 1'b1 || fail_bits !== 2'b01) begin bad++; $display("FAIL set_third_fail: got pulse=%b bits=%b want 1/01", fail_pulse, fail_bits); end
      end
      if (i == 3) begin
        total++; if (done !== 1'b0) begin bad++; $display("FAIL set_done_early: got %b want 0", done); end
      end
    end
    total++; if (done !== 1'b1 || pat_ready !== 1'b0) begin bad++; $display("FAIL set_done: got done=%b ready=%b want 1/0", done, pat_ready); end
    total++; if (pat_count !== 16'd5 || fail_count !== 16'd1) begin bad++; $display("FAIL set_counts: got %0d/%0d want 5/1", pat_count, fail_count); end
    total++; if (first_fail_idx !== 16'd2 || first_fail_vld !== 1'b1) begin bad++; $display("FAIL set_first: got idx=%0d vld=%b want 2/1", first_fail_idx, first_fail_vld); end
    // A sixth record offered in DONE must be ignored.
    pat_pi    = 5'b11111;
    pat_xpct  = 2'b00;
    pat_mask  = 2'b11;
    pat_last  = 1'b0;
    dut_po    = 2'b11;
    pat_valid = 1'b1;
    repeat (2 * SETTLE + 4) @(posedge clk);
    @(negedge clk);
    pat_valid = 1'b0;
    total++; if (dut_pi !== 5'b10000) begin bad++; $display("FAIL set_sixth_pi: got %b want 10000", dut_pi); end
    total++; if (pat_count !== 16'd5 || fail_count !== 16'd1) begin bad++; $display("FAIL set_sixth_counts: got %0d/%0d want 5/1", pat_count, fail_count); end
    total++; if (done !== 1'b1 || pat_ready !== 1'b0) begin bad++; $display("FAIL set_sixth_state: got done=%b ready=%b want 1/0", done, pat_ready); end
  endtask

  task automatic test_reset_mid_apply();
    do_reset();
    pat_pi    = 5'b10101;
    pat_xpct  = 2'b00;
    pat_mask  = 2'b11;
    pat_last  = 1'b1;
    dut_po    = 2'b11;
    pat_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pat_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++; if (dut_pi !== 5'b0) begin bad++; $display("FAIL mid_dut_pi: got %b want 00000", dut_pi); end
    total++; if (pat_count !== 16'd0 || fail_count !== 16'd0) begin bad++; $display("FAIL mid_counts: got %0d/%0d want 0/0", pat_count, fail_count); end
    total++; if ({fail_pulse, first_fail_vld, done, fail_bits} !== 5'b00000) begin bad++; $display("FAIL mid_flags: got %b want 00000", {fail_pulse, first_fail_vld, done, fail_bits}); end
    total++; if (pat_ready !== 1'b0) begin bad++; $display("FAIL mid_ready_low: got %b want 0", pat_ready); end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (pat_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_high: got %b want 1", pat_ready); end
    repeat (SETTLE + 3) @(posedge clk);
    @(negedge clk);
    total++; if (pat_count !== 16'd0 || fail_count !== 16'd0 || done !== 1'b0) begin bad++; $display("FAIL mid_not_counted: got %0d/%0d done=%b want 0/0/0", pat_count, fail_count, done); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      apply_pattern(mk_rec(5'b00111, 2'b00, 2'b11, 1'b0), 2'b11);
    end
    total++; if (pat_count_s !== 3'd7 || fail_count_s !== 3'd7) begin bad++; $display("FAIL sat_counts: got %0d/%0d want 7/7", pat_count_s, fail_count_s); end
    total++; if (first_fail_idx_s !== 3'd0 || first_fail_vld_s !== 1'b1) begin bad++; $display("FAIL sat_first: got idx=%0d vld=%b want 0/1", first_fail_idx_s, first_fail_vld_s); end
    total++; if (fail_pulse_s !== 1'b1 || fail_bits_s !== 2'b11) begin bad++; $display("FAIL sat_pulse: got pulse=%b bits=%b want 1/11", fail_pulse_s, fail_bits_s); end
    total++; if (pat_count !== 16'd10 || fail_count !== 16'd10) begin bad++; $display("FAIL sat_wide_counts: got %0d/%0d want 10/10", pat_count, fail_count); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_dont_care();
    test_full_set();
    test_reset_mid_apply();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
